// File: rtl/snd_dma_addr_if.sv
// CPU register bus for the sound DMA address generator.
// The CPU side drives select, strobes and write data; the DMA block returns registered read data.
interface snd_dma_addr_if;
    logic [3:0] bus_sel;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;

    modport master (
        output bus_sel,
        output bus_we,
        output bus_re,
        output bus_din,
        input  bus_dout
    );

    modport slave (
        input  bus_sel,
        input  bus_we,
        input  bus_re,
        input  bus_din,
        output bus_dout
    );
endinterface

// File: rtl/snd_dma_addr.sv
// Sound DMA address generator: CPU-visible frame start/end/control registers, word address
// counter with end-of-frame stop or repeat reload, feeding the MCU control stage compare.
module snd_dma_addr #(
    parameter int         AW      = 21,
    parameter logic [1:0] RST_CTL = 2'b00
) (
    input  logic                 clk32,
    input  logic                 por,
    snd_dma_addr_if.slave        bus,
    input  logic                 inc,
    output logic [AW:1]          snd,
    output logic [AW:1]          sft,
    output logic                 sndon,
    output logic                 sfrep,
    output logic                 frame_done
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [AW:1] start_reg;
    logic [AW:1] end_reg;
    logic [AW:1] snd_reg;
    logic [AW:1] sft_reg;
    logic        sfrep_reg;
    logic        frame_done_reg;
    logic [7:0]  dout_reg;
    logic [7:0]  rd_data;

    logic ctrl_wr;
    logic end_evt;
    logic advance;

    // Byte view of a word address: hi is zero-extended, lo carries an implicit zero bit 0.
    function automatic logic [7:0] addr_byte(input logic [AW:1] x, input logic [1:0] which);
        logic [7:0] b;
        case (which)
            2'd0:    b = 8'(x[AW:16]);
            2'd1:    b = x[15:8];
            default: b = {x[7:1], 1'b0};
        endcase
        return b;
    endfunction

    // The CPU write wins over a coincident inc, so a ctrl write masks any frame event.
    assign ctrl_wr = bus.bus_we && (bus.bus_sel == 4'd0);
    assign end_evt = (state_reg == RUN) && inc && !ctrl_wr && (snd_reg == sft_reg);
    assign advance = (state_reg == RUN) && inc && !ctrl_wr && (snd_reg != sft_reg);

    always_ff @(posedge clk32) begin
        if (por) begin
            state_reg <= RST_CTL[0] ? RUN : IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (ctrl_wr) begin
            state_next = bus.bus_din[0] ? RUN : IDLE;
        end else if (end_evt && !sfrep_reg) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        sndon      = (state_reg == RUN);
        sfrep      = sfrep_reg;
        frame_done = frame_done_reg;
        snd        = snd_reg;
        sft        = sft_reg;
        bus.bus_dout = dout_reg;
    end

    always_comb begin
        rd_data = 8'h00;
        case (bus.bus_sel)
            4'd0:    rd_data = {6'b0, sfrep_reg, state_reg == RUN};
            4'd1:    rd_data = addr_byte(start_reg, 2'd0);
            4'd2:    rd_data = addr_byte(start_reg, 2'd1);
            4'd3:    rd_data = addr_byte(start_reg, 2'd2);
            4'd4:    rd_data = addr_byte(snd_reg, 2'd0);
            4'd5:    rd_data = addr_byte(snd_reg, 2'd1);
            4'd6:    rd_data = addr_byte(snd_reg, 2'd2);
            4'd7:    rd_data = addr_byte(end_reg, 2'd0);
            4'd8:    rd_data = addr_byte(end_reg, 2'd1);
            4'd9:    rd_data = addr_byte(end_reg, 2'd2);
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk32) begin
        if (por) begin
            start_reg      <= '0;
            end_reg        <= '0;
            snd_reg        <= '0;
            sft_reg        <= '0;
            sfrep_reg      <= RST_CTL[1];
            frame_done_reg <= 1'b0;
            dout_reg       <= 8'h00;
        end else begin
            frame_done_reg <= end_evt;

            if (bus.bus_we) begin
                case (bus.bus_sel)
                    4'd1: start_reg[AW:16] <= bus.bus_din[AW-16:0];
                    4'd2: start_reg[15:8]  <= bus.bus_din;
                    4'd3: start_reg[7:1]   <= bus.bus_din[7:1];
                    4'd7: end_reg[AW:16]   <= bus.bus_din[AW-16:0];
                    4'd8: end_reg[15:8]    <= bus.bus_din;
                    4'd9: end_reg[7:1]     <= bus.bus_din[7:1];
                    default: ;
                endcase
            end

            // Reloads read start_reg/end_reg before any same-edge register write lands.
            if (ctrl_wr) begin
                sfrep_reg <= bus.bus_din[1];
                if (bus.bus_din[0] && state_reg == IDLE) begin
                    snd_reg <= start_reg;
                    sft_reg <= end_reg;
                end
            end else if (end_evt) begin
                if (sfrep_reg) begin
                    snd_reg <= start_reg;
                    sft_reg <= end_reg;
                end
            end else if (advance) begin
                snd_reg <= snd_reg + 1'b1;
            end

            if (bus.bus_re) begin
                dout_reg <= rd_data;
            end
        end
    end
endmodule
